// File: rtl/alu_core.sv
// 8-bit ALU stage behind the BI input register: binary add, logic ops and shift-right,
// plus a two-step decimal add/subtract sequence paced by a start/busy/done handshake.
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] ai_data,
  input  logic [WIDTH-1:0] bi_data,
  input  logic             carry_in,
  input  logic             dec_en,
  input  logic             dec_sub,
  output logic [WIDTH-1:0] add_data,
  output logic             acr,
  output logic             avr,
  output logic             hc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    DCORR = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    OP_SUM = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_EOR = 3'b011,
    OP_SR  = 3'b100
  } op_t;

  localparam logic [WIDTH:0] ADJ_LO   = (WIDTH+1)'(6);
  localparam logic [WIDTH:0] ADJ_HI   = (WIDTH+1)'(96);
  localparam logic [WIDTH:0] BCD_MAX  = (WIDTH+1)'(153);

  state_t           state;

  // Operands captured at acceptance so upstream registers may change mid-operation.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [2:0]       op_q;
  logic             dec_q;
  logic             sub_q;

  logic [WIDTH:0]   sum_full;
  logic [4:0]       low_nib;
  logic [WIDTH-1:0] calc_res;
  logic             calc_acr;
  logic             calc_avr;
  logic             calc_hc;
  logic             calc_dec;

  logic [WIDTH:0]   dadj;
  logic [WIDTH-1:0] corr_res;
  logic             corr_acr;

  // Binary stage, evaluated from the latched operands.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    calc_res = '0;
    calc_acr = 1'b0;
    calc_avr = 1'b0;
    calc_hc  = 1'b0;
    sum_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    low_nib  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, cin_q};
    case (op_q)
      OP_SUM: begin
        calc_res = sum_full[WIDTH-1:0];
        calc_acr = sum_full[WIDTH];
        calc_hc  = low_nib[4];
        calc_avr = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: calc_res = a_q & b_q;
      OP_OR:  calc_res = a_q | b_q;
      OP_EOR: calc_res = a_q ^ b_q;
      OP_SR: begin
        calc_res = {cin_q, a_q[WIDTH-1:1]};
        calc_acr = a_q[0];
      end
      default: ;
    endcase
    calc_dec = (op_q == OP_SUM) && dec_q;
  end

  // BCD correction applied to the registered binary sum and its flags.
  always_comb begin
    // NOTE: blocking assignments here are deliberate; each adjustment builds on the previous one.
    dadj     = {1'b0, add_data};
    corr_acr = acr;
    if (!sub_q) begin
      if (hc || (add_data[3:0] > 4'd9)) dadj = dadj + ADJ_LO;
      if (acr || (dadj > BCD_MAX)) begin
        dadj     = dadj + ADJ_HI;
        corr_acr = 1'b1;
      end
    end else begin
      if (!hc)  dadj = dadj - ADJ_LO;
      if (!acr) dadj = dadj - ADJ_HI;
    end
    corr_res = dadj[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset clears the operand latches too, so an aborted operation leaves no stale state.
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= 3'b000;
      dec_q    <= 1'b0;
      sub_q    <= 1'b0;
      add_data <= '0;
      acr      <= 1'b0;
      avr      <= 1'b0;
      hc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= ai_data;
            b_q   <= bi_data;
            cin_q <= carry_in;
            op_q  <= op_sel;
            dec_q <= dec_en;
            sub_q <= dec_sub;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          add_data <= calc_res;
          acr      <= calc_acr;
          avr      <= calc_avr;
          hc       <= calc_hc;
          if (calc_dec) begin
            state <= DCORR;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        DCORR: begin
          // Overflow and half carry keep their binary-stage values.
          add_data <= corr_res;
          acr      <= corr_acr;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
